// File: rtl/data_memory_stack_pkg.sv
// dm_pkg: shared constants, request encoding and decode helper for data_memory_stack.
// Ports: none (package).
package dm_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_STACK_DEPTH = 8;
   localparam int DEPTH = 2 ** DEF_ADDR_W;
   localparam int STACK_BASE = DEPTH - DEF_STACK_DEPTH;
   typedef enum logic [5:0] {
      REQ_NONE    = 6'b000001,
      REQ_RD      = 6'b000010,
      REQ_WR      = 6'b000100,
      REQ_PUSH    = 6'b001000,
      REQ_POP     = 6'b010000,
      REQ_ILLEGAL = 6'b100000
   } req_t;
   // More than one of En/Push/Pop in a cycle is rejected as a whole.
   function automatic req_t decode_req(input logic en, input logic we, input logic push, input logic pop);
      logic [1:0] n;
      n = {1'b0, en} + {1'b0, push} + {1'b0, pop};
      return n > 2'd1 ? REQ_ILLEGAL : en ? (we ? REQ_WR : REQ_RD) : push ? REQ_PUSH : pop ? REQ_POP : REQ_NONE;
   endfunction
endpackage

// File: rtl/data_memory_stack_if.sv
// data_memory_stack_if: CPU-side bus of the data memory/stack.
// master (CPU): drives En/We/Push/Pop/Address/Data_in; slave (memory): drives Data_out/Valid/Sp/Empty/Full/Err.
interface data_memory_stack_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              En;
   logic              We;
   logic              Push;
   logic              Pop;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] Data_in;
   logic [DATA_W-1:0] Data_out;
   logic              Valid;
   logic [ADDR_W:0]   Sp;
   logic              Empty;
   logic              Full;
   logic              Err;
   modport master (output En, We, Push, Pop, Address, Data_in,
                   input Data_out, Valid, Sp, Empty, Full, Err);
   modport slave  (input En, We, Push, Pop, Address, Data_in,
                   output Data_out, Valid, Sp, Empty, Full, Err);
endinterface

// File: rtl/data_memory_stack_stack_ptr.sv
// dm_stack_ptr: stack pointer register with full/empty flags and push/pop legality.
// In: Clk, Rst, push_i, pop_i (decoded single requests). Out: sp_o, full_o, empty_o, push_ok_o, pop_ok_o.
module dm_stack_ptr
   import dm_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            push_i,
   input  logic            pop_i,
   output logic [ADDR_W:0] sp_o,
   output logic            full_o,
   output logic            empty_o,
   output logic            push_ok_o,
   output logic            pop_ok_o
);
   localparam int MEM_DEPTH = 2 ** ADDR_W;
   localparam int BASE = MEM_DEPTH - STACK_DEPTH;
   logic [ADDR_W:0] sp_q, sp_d;
   // Sp is one bit wider than the address so "empty" (== DEPTH) is representable.
   always_comb begin
      empty_o   = sp_q == (ADDR_W+1)'(MEM_DEPTH);
      full_o    = sp_q == (ADDR_W+1)'(BASE);
      push_ok_o = push_i && !full_o;
      pop_ok_o  = pop_i && !empty_o;
      sp_d      = push_ok_o ? sp_q - (ADDR_W+1)'(1) : pop_ok_o ? sp_q + (ADDR_W+1)'(1) : sp_q;
   end
   always_ff @(posedge Clk) begin
      if (Rst) sp_q <= (ADDR_W+1)'(MEM_DEPTH);
      else     sp_q <= sp_d;
   end
   assign sp_o = sp_q;
endmodule

// File: rtl/data_memory_stack.sv
// data_memory_stack: single-port word RAM with registered reads and a hardware stack in its top words.
// In: Clk, Rst, bus.En/We/Push/Pop/Address/Data_in. Out: bus.Data_out/Valid/Sp/Empty/Full/Err.
module data_memory_stack
   import dm_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
   input logic Clk,
   input logic Rst,
   data_memory_stack_if.slave bus
);
   localparam int MEM_DEPTH = 2 ** ADDR_W;
   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d, err_q, err_d;
   logic [ADDR_W:0]   sp;
   logic [ADDR_W-1:0] push_addr;
   logic              full, empty, push_ok, pop_ok;
   req_t              req;
   dm_stack_ptr #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_sp (
      .Clk       (Clk),
      .Rst       (Rst),
      .push_i    (req == REQ_PUSH),
      .pop_i     (req == REQ_POP),
      .sp_o      (sp),
      .full_o    (full),
      .empty_o   (empty),
      .push_ok_o (push_ok),
      .pop_ok_o  (pop_ok)
   );
   // Push writes below the current top; the low bits of DEPTH wrap to the last word as intended.
   always_comb begin
      req       = decode_req(bus.En, bus.We, bus.Push, bus.Pop);
      push_addr = sp[ADDR_W-1:0] - ADDR_W'(1);
      valid_d   = (req == REQ_RD) || pop_ok;
      err_d     = (req == REQ_ILLEGAL) || ((req == REQ_PUSH) && !push_ok) || ((req == REQ_POP) && !pop_ok);
      dout_d    = (req == REQ_RD) ? mem_q[bus.Address] : pop_ok ? mem_q[sp[ADDR_W-1:0]] : dout_q;
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (req == REQ_WR) mem_q[bus.Address] <= bus.Data_in;
         else if (push_ok)  mem_q[push_addr] <= bus.Data_in;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end
   assign bus.Data_out = dout_q;
   assign bus.Valid    = valid_q;
   assign bus.Err      = err_q;
   assign bus.Sp       = sp;
   assign bus.Full     = full;
   assign bus.Empty    = empty;
endmodule

// File: tb/tb_data_memory_stack.sv
// tb_data_memory_stack: directed self-checking bench for data_memory_stack.
module tb_data_memory_stack;
   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int checks = 0;
   int errors = 0;
   data_memory_stack_if #(.DATA_W(8), .ADDR_W(5)) bus ();
   data_memory_stack #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(8)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input logic en, input logic we, input logic push, input logic pop,
                      input logic [4:0] a, input logic [7:0] d);
      bus.En = en; bus.We = we; bus.Push = push; bus.Pop = pop;
      bus.Address = a; bus.Data_in = d;
      @(posedge Clk);
      #1;
   endtask
   task automatic st(input string tag, input int sp, input int dout, input int valid, input int err);
      chk({tag, "_sp"}, 32'(bus.Sp), 32'(sp));
      chk({tag, "_dout"}, 32'(bus.Data_out), 32'(dout));
      chk({tag, "_valid"}, 32'(bus.Valid), 32'(valid));
      chk({tag, "_err"}, 32'(bus.Err), 32'(err));
   endtask
   initial begin
      bus.En = 0; bus.We = 0; bus.Push = 0; bus.Pop = 0; bus.Address = '0; bus.Data_in = '0;
      // reset beats a coincident push
      Rst = 1;
      cyc(0, 0, 1, 0, 5'd0, 8'h99);
      Rst = 0;
      st("rst", 32, 0, 0, 0);
      chk("rst_empty", 32'(bus.Empty), 1);
      chk("rst_full", 32'(bus.Full), 0);
      cyc(1, 0, 0, 0, 5'd7, 8'h00);
      st("rd7", 32, 0, 1, 0);
      // random access
      cyc(1, 1, 0, 0, 5'd3, 8'hA5);
      st("wr3", 32, 0, 0, 0);
      cyc(1, 0, 0, 0, 5'd3, 8'h00);
      st("rd3", 32, 8'hA5, 1, 0);
      // stack order
      cyc(0, 0, 1, 0, 5'd0, 8'h11);
      st("push11", 31, 8'hA5, 0, 0);
      chk("push11_empty", 32'(bus.Empty), 0);
      cyc(0, 0, 1, 0, 5'd0, 8'h22);
      st("push22", 30, 8'hA5, 0, 0);
      cyc(0, 0, 1, 0, 5'd0, 8'h33);
      st("push33", 29, 8'hA5, 0, 0);
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      st("pop33", 30, 8'h33, 1, 0);
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      st("pop22", 31, 8'h22, 1, 0);
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      st("pop11", 32, 8'h11, 1, 0);
      chk("pop11_empty", 32'(bus.Empty), 1);
      // underflow
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      st("underflow", 32, 8'h11, 0, 1);
      cyc(0, 0, 0, 0, 5'd0, 8'h00);
      st("idle", 32, 8'h11, 0, 0);
      // fill to full
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1, 0, 5'd0, 8'(8'h80 + i));
         chk("fill_sp", 32'(bus.Sp), 32'(31 - i));
      end
      chk("fill_full", 32'(bus.Full), 1);
      cyc(0, 0, 1, 0, 5'd0, 8'hFF);
      st("overflow", 24, 8'h11, 0, 1);
      chk("overflow_full", 32'(bus.Full), 1);
      cyc(1, 0, 0, 0, 5'd23, 8'h00);
      st("rd23", 24, 8'h00, 1, 0);
      cyc(1, 0, 0, 0, 5'd24, 8'h00);
      st("rd24", 24, 8'h87, 1, 0);
      // conflicting push + write
      cyc(1, 1, 1, 0, 5'd5, 8'h66);
      st("conflict", 24, 8'h87, 0, 1);
      cyc(1, 0, 0, 0, 5'd5, 8'h00);
      st("rd5", 24, 8'h00, 1, 0);
      // drain in LIFO order
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 1, 5'd0, 8'h00);
         chk("drain_dout", 32'(bus.Data_out), 32'(8'h87 - i));
         chk("drain_sp", 32'(bus.Sp), 32'(25 + i));
      end
      chk("drain_empty", 32'(bus.Empty), 1);
      // aliasing: random write over the top of stack
      cyc(0, 0, 1, 0, 5'd0, 8'h44);
      st("push44", 31, 8'h80, 0, 0);
      cyc(1, 1, 0, 0, 5'd31, 8'h55);
      st("wr31", 31, 8'h80, 0, 0);
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      st("pop55", 32, 8'h55, 1, 0);
      // back-to-back push/pop
      cyc(0, 0, 1, 0, 5'd0, 8'h77);
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      st("b2b", 32, 8'h77, 1, 0);
      cyc(0, 0, 0, 0, 5'd0, 8'h00);
      st("b2b_idle", 32, 8'h77, 0, 0);
      // reset discards a coincident pop and clears memory
      cyc(0, 0, 1, 0, 5'd0, 8'h12);
      chk("pre_rst_sp", 32'(bus.Sp), 31);
      Rst = 1;
      cyc(0, 0, 0, 1, 5'd0, 8'h00);
      Rst = 0;
      st("rst2", 32, 0, 0, 0);
      cyc(1, 0, 0, 0, 5'd31, 8'h00);
      st("rd31_after_rst", 32, 0, 1, 0);
      cyc(1, 0, 0, 0, 5'd3, 8'h00);
      st("rd3_after_rst", 32, 0, 1, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_memory_stack.md
# data_memory_stack

Parametrised successor to the CPU's 8-bit data memory: a synchronous single-port word RAM with registered reads, plus a hardware stack carved from the top of the same array. The stack is managed by an internal stack pointer with push/pop, full/empty flags and an error strobe. It sits between the CPU datapath (load/store, CALL/RET, PUSH/POP) and nothing else. One access per cycle.

## Interface
- `DATA_W`, default 8: word width.
- `ADDR_W`, default 5: address width. Depth is `DEPTH = 2**ADDR_W`.
- `STACK_DEPTH`, default 8: words reserved for the stack at addresses `DEPTH-STACK_DEPTH .. DEPTH-1`. Legal range is 1..DEPTH.
- `Clk`, input, 1: single clock, rising edge.
- `Rst`, input, 1: reset, synchronous, active-high.
- `En`, input, 1: random-access request.
- `We`, input, 1: qualifies `En`. 1 = write, 0 = read.
- `Push`, input, 1: push `Data_in` onto the stack.
- `Pop`, input, 1: pop the top of stack to `Data_out`.
- `Address`, input, ADDR_W: random-access address. Ignored for push/pop.
- `Data_in`, input, DATA_W: write/push data.
- `Data_out`, output, DATA_W: registered read/pop data.
- `Valid`, output, 1: one-cycle pulse when `Data_out` was updated.
- `Sp`, output, ADDR_W+1: stack pointer, i.e. the address of the current top.
- `Empty`, output, 1: asserted when `Sp == DEPTH`.
- `Full`, output, 1: asserted when `Sp == DEPTH-STACK_DEPTH`.
- `Err`, output, 1: one-cycle pulse on an illegal request.

## Operation
- **Request decode.** Exactly one of `Push`, `Pop`, `En` may be high per cycle.
  - If two or more are high: no memory or Sp change, `Err`=1, `Valid`=0, `Data_out` is held.
- **Random write** (`En`=1, `We`=1): `mem[Address] <= Data_in`.
  - `Data_out` is held and `Valid`=0.
  - Writes into the stack region are permitted and do not touch `Sp`.
- **Random read** (`En`=1, `We`=0): `Data_out <= mem[Address]`, `Valid`=1.
- **Push:**
  - Not `Full`: `mem[Sp-1] <= Data_in`, `Sp <= Sp-1`.
  - `Full`: no write, `Sp` unchanged, `Err`=1.
- **Pop:**
  - Not `Empty`: `Data_out <= mem[Sp]`, `Sp <= Sp+1`, `Valid`=1.
  - `Empty`: `Data_out` held, `Valid`=0, `Err`=1.
- **Idle** (no request): all state held, `Valid`=0, `Err`=0.
- **Stack control states**, encoded as flags derived combinationally from `Sp`: EMPTY → PARTIAL → FULL.
  - A push moves toward FULL; a pop moves toward EMPTY.
  - When `STACK_DEPTH`=1, a single push goes directly EMPTY→FULL.
- **Address arithmetic.** `Sp` is ADDR_W+1 bits wide so that the value `DEPTH` is representable.
  - Memory is indexed by `Sp[ADDR_W-1:0]`.
  - No wrap-around is possible, because the full/empty guards block it.

## Timing
- **Reset** (`Rst`=1 at a rising edge), which overrides every request in the same cycle:
  - all memory words = 0
  - `Data_out`=0, `Valid`=0, `Err`=0
  - `Sp`=DEPTH, `Empty`=1, `Full`=0
- **Reset mid-operation:** a push or pop coinciding with `Rst` is discarded.
- **Latency:**
  - Read/pop data and `Valid` appear one cycle after the request edge.
  - Write/push data are visible to a read issued on the next cycle.
  - `Sp`, `Full` and `Empty` update at the request edge. The flags are combinational from the registered `Sp`, so there is no extra lag.
- **Back-to-back operation:** push, pop, read and write may be issued every cycle with no bubbles. Push followed by pop on consecutive cycles returns the pushed value.
- **Pulse width:** `Err` and `Valid` are registered and last exactly one cycle per offending or productive request.

## Structure
- A shared package `dm_pkg` holds:
  - localparams `DEPTH` and `STACK_BASE = DEPTH-STACK_DEPTH`
  - the request-decode one-hot constants (`REQ_NONE`, `REQ_RD`, `REQ_WR`, `REQ_PUSH`, `REQ_POP`, `REQ_ILLEGAL`)
- Sub-module `dm_stack_ptr` contains the `Sp` register, the full/empty compare and the push/pop legality logic. It outputs `Sp`, `Full`, `Empty`, `push_ok` and `pop_ok`.
- The top level contains the array, the request decode, and the `Data_out`/`Valid`/`Err` registers.

## Test plan
- **Reset:** assert `Rst` for 1 cycle with `Push`=1 → `Sp`=32, `Empty`=1, `Data_out`=0, and a read of address 7 returns 0.
- **Random access:** write 0xA5 to address 3, read address 3 on the next cycle → `Data_out`=0xA5 with `Valid`=1 one cycle after the read. The intervening write cycle shows `Valid`=0.
- **Stack order:** push 0x11, 0x22, 0x33, then pop three times → `Data_out` is 0x33, 0x22, 0x11 on successive cycles, and `Sp` goes 29 → 32.
- **Overflow:** push 8 times to reach `Full`=1 with `Sp`=24, then a 9th push with 0xFF → `Err`=1, `Sp`=24, and `mem[23]` is unchanged.
- **Underflow and conflict:**
  - Pop while `Empty` → `Err`=1, `Valid`=0, `Data_out` held.
  - `Push`=1 and `En`=1 in the same cycle → `Err`=1, with no state change.
- **Aliasing:** push 0x44 (`Sp`=31), then randomly write 0x55 to address 31, then pop → `Data_out`=0x55 and `Sp`=32.
